// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control for the datapath.
// One instruction per pass through T0..T5. Fetch is T0..T2; T3..T5 execute
// three-register ALU instructions (Ra <= Rb op Rc). Every strobe is a decode
// of the current state, plus the IR opcode in T3/T4. The strobes are held for
// the whole cycle, and the datapath captures them on the next rising edge.
//
// Memory handshake: Mem_ready acts as the ready of the read that T1 issues.
// The read (Read + MDRin) stays asserted for every cycle spent in T1. The
// sequencer leaves T1 only on a rising edge where Mem_ready=1, so the MDR
// value captured on that edge is the one used by T2.
module control_sequencer #(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic [IRW-1:0] IR,
    input  logic           Mem_ready,
    input  logic           Stop,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           Rout,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Rin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           AND,
    output logic           OR,
    output logic           ADD,
    output logic           SUB,
    output logic           Run,
    output logic           Illegal,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_T0     = 3'd1,
        S_T1     = 3'd2,
        S_T2     = 3'd3,
        S_T3     = 3'd4,
        S_T4     = 3'd5,
        S_T5     = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t         state;
    logic [OPW-1:0] opcode;
    logic           is_alu;
    logic           unused_ir;

    // The register fields are consumed by the datapath through Gra/Grb/Grc.
    // Only the opcode is decoded here.
    assign opcode    = IR[IRW-1 -: OPW];
    assign unused_ir = ^IR[IRW-OPW-1:0];
    assign dbg_state = state;

    // Opcode classification; only meaningful in T3/T4, when IR holds the fetched word.
    always_comb begin
        is_alu = (opcode == OP_AND) || (opcode == OP_OR) ||
                 (opcode == OP_ADD) || (opcode == OP_SUB);
    end

    // State register. Clear aborts any instruction and wins over every other input.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= Mem_ready ? S_T2 : S_T1;
                S_T2:    state <= S_T3;
                S_T3: begin
                    if (is_alu)                 state <= S_T4;
                    else if (opcode == OP_HALT) state <= S_HALTED;
                    else                        state <= S_T0;
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= Stop ? S_HALTED : S_T0;
                S_HALTED: state <= S_HALTED;
                default: state <= S_RESET;
            endcase
        end
    end

    // Strobe decode. RESET and HALTED drive nothing.
    // Zin (T0/T4) and Zlowout (T1/T5) never share a state.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Rout    = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Rin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        AND     = 1'b0;
        OR      = 1'b0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        Run     = 1'b0;
        Illegal = 1'b0;
        case (state)
            S_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                // While waiting, PC is reloaded from an unchanged Z, which is harmless.
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_alu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if ((opcode != OP_NOP) && (opcode != OP_HALT)) begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                Run  = 1'b1;
                Grc  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                AND  = (opcode == OP_AND);
                OR   = (opcode == OP_OR);
                ADD  = (opcode == OP_ADD);
                SUB  = (opcode == OP_SUB);
            end
            S_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

endmodule
